// File: rtl/fir_result_sink.sv
// rtl/fir_result_sink.sv - FIR result decimator, offset-binary to two's complement converter and output FIFO
module fir_result_sink #(
  parameter int W          = 14,
  parameter int OSR        = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int LENGTH     = 24000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overflow,
  output logic [15:0]  drop_count,
  output logic         done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [PW-1:0] phase;
  logic [31:0]   vcount;

  logic empty, full, pop, kept, push, drop, last;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && out_ready;
  assign kept  = in_valid && (phase == '0) && !done;
  // A full FIFO still accepts a kept sample when the head leaves in the same cycle.
  assign push  = kept && (!full || pop);
  assign drop  = kept && full && !pop;
  assign last  = (LENGTH != 0) && (vcount == 32'(LENGTH - 1));

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[AW-1:0]] <= {~in_data[W-1], in_data[W-2:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      phase      <= '0;
      vcount     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      done       <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;

      // A gap in in_valid realigns decimation so the next valid result is kept.
      if (!in_valid)
        phase <= '0;
      else if (!done)
        phase <= (phase == PW'(OSR - 1)) ? '0 : phase + 1'b1;

      if (in_valid && !done) begin
        vcount <= vcount + 1'b1;
        if (last)
          done <= 1'b1;
      end

      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF)
          drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_result_sink.sv
// tb/tb_fir_result_sink.sv - self-checking bench for fir_result_sink across three OSR/LENGTH configurations
module tb_fir_result_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic [13:0] od [3];
  logic        ov [3];
  logic        ovf [3];
  logic [15:0] dc [3];
  logic        dn [3];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fir_result_sink #(.W(14), .OSR(1), .FIFO_DEPTH(16), .LENGTH(0)) u_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .overflow(ovf[0]), .drop_count(dc[0]), .done(dn[0]));

  fir_result_sink #(.W(14), .OSR(4), .FIFO_DEPTH(16), .LENGTH(0)) u_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .overflow(ovf[1]), .drop_count(dc[1]), .done(dn[1]));

  fir_result_sink #(.W(14), .OSR(2), .FIFO_DEPTH(16), .LENGTH(10)) u_c (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .overflow(ovf[2]), .drop_count(dc[2]), .done(dn[2]));

  // Reference model: per instance, a queue of expected samples plus counters.
  int          osr_v [3] = '{1, 4, 2};
  int          len_v [3] = '{0, 0, 10};
  int          run   [3];
  int          vc    [3];
  int          head  [3];
  int          tail  [3];
  int          drops [3];
  bit          mdone [3];
  bit          movf  [3];
  logic [13:0] mq [0:2][0:255];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        run[i] = 0; vc[i] = 0; head[i] = 0; tail[i] = 0;
        drops[i] = 0; mdone[i] = 0; movf[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit keep, pop_m, mdone_nxt;
        int cnt;
        cnt = tail[i] - head[i];
        pop_m = (cnt > 0) && out_ready;
        keep = 0;
        mdone_nxt = mdone[i];
        if (!in_valid) run[i] = 0;
        else if (!mdone[i]) begin
          keep = (run[i] % osr_v[i]) == 0;
          run[i]++;
          vc[i]++;
          if (len_v[i] != 0 && vc[i] == len_v[i]) mdone_nxt = 1;
        end
        if (pop_m) head[i]++;
        if (keep) begin
          if (cnt < 16 || pop_m) begin
            mq[i][tail[i] % 256] = 14'(int'(in_data) - 8192);
            tail[i]++;
          end else begin
            movf[i] = 1;
            if (drops[i] < 65535) drops[i]++;
          end
        end
        mdone[i] = mdone_nxt;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int cnt;
      cnt = tail[i] - head[i];
      check($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(cnt > 0));
      if (cnt > 0)
        check($sformatf("out_data[%0d]", i), 32'(od[i]), 32'(mq[i][head[i] % 256]));
      check($sformatf("overflow[%0d]", i), 32'(ovf[i]), 32'(movf[i]));
      check($sformatf("drop_count[%0d]", i), 32'(dc[i]), 32'(drops[i]));
      check($sformatf("done[%0d]", i), 32'(dn[i]), 32'(mdone[i]));
    end
  endtask

  task automatic cyc(input logic v, input logic [13:0] d, input logic r);
    in_valid = v; in_data = d; out_ready = r;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  logic [13:0] t1 [4];

  initial begin
    t1 = '{14'h2000, 14'h3FFF, 14'h0000, 14'h2001};
    do_reset();
    check("reset out_valid", 32'(ov[0]), 32'd0);
    check("reset out_data", 32'(od[0]), 32'd0);
    check("reset drop_count", 32'(dc[0]), 32'd0);
    check("reset done", 32'(dn[2]), 32'd0);

    // Conversion corners, one cycle latency at OSR=1
    cyc(1, t1[0], 1); check("conv 0x2000", 32'(od[0]), 32'h0000);
    cyc(1, t1[1], 1); check("conv 0x3FFF", 32'(od[0]), 32'h1FFF);
    cyc(1, t1[2], 1); check("conv 0x0000", 32'(od[0]), 32'h2000);
    cyc(1, t1[3], 1); check("conv 0x2001", 32'(od[0]), 32'h0001);
    cyc(0, '0, 1);

    // Ramp with a one-cycle gap at k=5
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k == 5) cyc(0, 14'(14'h2000 + k), 1);
      else        cyc(1, 14'(14'h2000 + k), 1);
      if (k == 6) check("osr4 realign after gap", 32'(od[1]), 32'd6);
    end
    cyc(0, '0, 1);

    // Back-pressure: fill, overflow, simultaneous push+pop on full, drain
    do_reset();
    for (int k = 0; k < 20; k++) cyc(1, 14'(14'h2000 + k), 0);
    check("full head held", 32'(od[0]), 32'd0);
    check("overflow set", 32'(ovf[0]), 32'd1);
    check("drops 4", 32'(dc[0]), 32'd4);
    cyc(1, 14'h2100, 1);
    check("push+pop on full drops", 32'(dc[0]), 32'd4);
    for (int k = 0; k < 18; k++) cyc(0, '0, 1);
    check("drained", 32'(ov[0]), 32'd0);

    // LENGTH stop at OSR=2
    do_reset();
    for (int k = 0; k < 15; k++) begin
      cyc(1, 14'(14'h2000 + k), 1);
      if (k == 8) check("done before 10th", 32'(dn[2]), 32'd0);
      if (k == 9) check("done after 10th", 32'(dn[2]), 32'd1);
    end
    check("no drops after done", 32'(dc[2]), 32'd0);

    // Asynchronous reset mid-stream with samples queued
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1, 14'(14'h2200 + k), 0);
    #2 rst = 1'b0;
    #1;
    check("async rst out_valid", 32'(ov[0]), 32'd0);
    check("async rst done", 32'(dn[2]), 32'd0);
    check("async rst drops", 32'(dc[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 14'h2345, 0);
    check("first after reset", 32'(od[0]), 32'h0345);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 400; k++)
      cyc(($urandom_range(0, 9) < 8), 14'($urandom), ($urandom_range(0, 1) == 1));
    for (int k = 0; k < 20; k++) cyc(0, '0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
